hit_tagger: RTL and testbench

HIT_TAGGER -- requirements
Module: hit_tagger

---
 rtl/hit_tagger_pkg.sv | 20 ++
 rtl/hit_tagger_if.sv | 23 ++
 rtl/hit_fifo.sv | 55 +++++
 rtl/hit_tagger.sv | 118 +++++++++++
 tb/tb_hit_tagger.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/hit_tagger_pkg.sv
// Shared widths, FSM encoding and event record for the hit tagger slice.
package hit_tagger_pkg;

  localparam int COARSE_W_DEF   = 12;
  localparam int WIDTH_W_DEF    = 12;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int FINE_W         = 3;

  typedef enum logic {
    IDLE = 1'b0,
    LEAD = 1'b1
  } tag_state_t;

  typedef struct packed {
    logic [COARSE_W_DEF+FINE_W-1:0] lead;
    logic [WIDTH_W_DEF-1:0]         width;
    logic                           sat;
  } hit_evt_t;

endpackage

// File: rtl/hit_tagger_if.sv
// Event output stream: valid/ready handshake carrying {lead, width, sat}.
interface hit_tagger_if
  import hit_tagger_pkg::*;
#(
  parameter int COARSE_W = COARSE_W_DEF,
  parameter int WIDTH_W  = WIDTH_W_DEF
);
  logic                       out_valid;
  logic                       out_ready;
  logic [COARSE_W+FINE_W-1:0] out_lead;
  logic [WIDTH_W-1:0]         out_width;
  logic                       out_sat;

  modport master (
    output out_valid, out_lead, out_width, out_sat,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_lead, out_width, out_sat,
    output out_ready
  );
endinterface

// File: rtl/hit_fifo.sv
// First-word-fall-through event buffer; head is visible combinationally while non-empty.
module hit_fifo
  import hit_tagger_pkg::*;
#(
  parameter type T     = hit_evt_t,
  parameter int  DEPTH = FIFO_DEPTH_DEF
) (
  input  logic clk300,
  input  logic rst,
  input  logic wr_en,
  input  T     wr_data,
  input  logic rd_en,
  output T     rd_data,
  output logic full,
  output logic empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           do_wr, do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en & ~empty;
  // A pop frees the slot this cycle, so a write into a full FIFO still lands
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk300 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hit_tagger.sv
// Pairs rising/falling pin edges into timestamped pulse events with width saturation.
module hit_tagger
  import hit_tagger_pkg::*;
#(
  parameter int COARSE_W   = COARSE_W_DEF,
  parameter int WIDTH_W    = WIDTH_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk300,
  input  logic                rst,
  input  logic                str,
  input  logic [FINE_W-1:0]   ptime,
  input  logic                pin_out,
  input  logic                clr_ovf,
  output logic                ovf,
  hit_tagger_if.master        evt
);
  localparam int TS_W = COARSE_W + FINE_W;
  localparam logic [TS_W-1:0] MAX_W = TS_W'({WIDTH_W{1'b1}});

  typedef struct packed {
    logic [TS_W-1:0]    lead;
    logic [WIDTH_W-1:0] width;
    logic               sat;
  } evt_t;

  logic [COARSE_W-1:0] coarse;
  tag_state_t          state, state_n;
  logic [TS_W-1:0]     lead_ts, lead_n;
  logic [TS_W-1:0]     edge_ts, tmo_ts, age;
  logic                emit, pop, drop, full, empty;
  evt_t                evt_w, head;

  assign edge_ts = {coarse, ptime};
  // Latest fine position in this cycle: the pulse cannot end later than this
  assign tmo_ts  = {coarse, {FINE_W{1'b1}}};

  always_ff @(posedge clk300 or posedge rst) begin
    if (rst) coarse <= '0;
    else     coarse <= coarse + 1'b1;
  end

  always_ff @(posedge clk300 or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lead_ts <= '0;
    end else begin
      state   <= state_n;
      lead_ts <= lead_n;
    end
  end

  always_comb begin
    state_n    = state;
    lead_n     = lead_ts;
    emit       = 1'b0;
    age        = '0;
    evt_w      = '0;
    evt_w.lead = lead_ts;
    unique case (state)
      IDLE: begin
        if (str && pin_out) begin
          lead_n  = edge_ts;
          state_n = LEAD;
        end
      end
      LEAD: begin
        if (str) begin
          if (pin_out) begin
            lead_n = edge_ts;
          end else begin
            age     = edge_ts - lead_ts;
            emit    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          age = tmo_ts - lead_ts;
          if (age > MAX_W) begin
            emit    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    evt_w.sat   = (age > MAX_W);
    evt_w.width = evt_w.sat ? '1 : age[WIDTH_W-1:0];
  end

  hit_fifo #(
    .T     (evt_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk300  (clk300),
    .rst     (rst),
    .wr_en   (emit),
    .wr_data (evt_w),
    .rd_en   (evt.out_ready),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign pop  = ~empty & evt.out_ready;
  assign drop = emit & full & ~pop;

  always_ff @(posedge clk300 or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

  assign evt.out_valid = ~empty;
  assign evt.out_lead  = head.lead;
  assign evt.out_width = head.width;
  assign evt.out_sat   = head.sat;

endmodule

// File: tb/tb_hit_tagger.sv
// Directed bench for hit_tagger with a cycle-level event-queue model checked every cycle.
module tb_hit_tagger;
  localparam int CW     = 12;
  localparam int WW     = 12;
  localparam int DEPTH  = 4;
  localparam int TSMASK = (1 << (CW + 3)) - 1;
  localparam int MAXW   = (1 << WW) - 1;

  logic       clk300 = 1'b0;
  logic       rst = 1'b1;
  logic       str = 1'b0;
  logic       pin_out = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [2:0] ptime = 3'd0;
  logic       ovf;

  hit_tagger_if #(.COARSE_W(CW), .WIDTH_W(WW)) bus ();

  hit_tagger #(.COARSE_W(CW), .WIDTH_W(WW), .FIFO_DEPTH(DEPTH)) dut (
    .clk300  (clk300),
    .rst     (rst),
    .str     (str),
    .ptime   (ptime),
    .pin_out (pin_out),
    .clr_ovf (clr_ovf),
    .ovf     (ovf),
    .evt     (bus)
  );

  always #5 clk300 = ~clk300;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending lead as a plain integer timestamp, output FIFO as a queue.
  typedef struct {int lead; int width; int sat;} ev_t;
  ev_t q[$];
  int  m_coarse = 0;
  int  m_lead = 0;
  bit  m_have = 1'b0;
  bit  m_ovf = 1'b0;
  int  t, w;
  bit  m_pop, m_new, m_drop;
  ev_t e;

  always @(negedge clk300) begin
    if (rst) begin
      q.delete();
      m_have = 1'b0; m_ovf = 1'b0; m_coarse = 0;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_lead",  bus.out_lead,  0);
      chk("rst_width", bus.out_width, 0);
      chk("rst_sat",   bus.out_sat,   0);
      chk("rst_ovf",   ovf,           0);
    end else begin
      chk("valid", bus.out_valid, (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) begin
        chk("lead",  bus.out_lead,  q[0].lead);
        chk("width", bus.out_width, q[0].width);
        chk("sat",   bus.out_sat,   q[0].sat);
      end
      chk("ovf", ovf, m_ovf);
      m_pop = (q.size() > 0) && bus.out_ready;
      m_new = 1'b0;
      t = m_coarse * 8 + int'(ptime);
      if (str && pin_out) begin
        m_lead = t; m_have = 1'b1;
      end else if (str && m_have) begin
        w = (t - m_lead) & TSMASK;
        m_new = 1'b1; m_have = 1'b0;
      end else if (!str && m_have) begin
        w = (m_coarse * 8 + 7 - m_lead) & TSMASK;
        if (w > MAXW) begin m_new = 1'b1; m_have = 1'b0; end
      end
      if (m_new) begin
        e.lead = m_lead; e.sat = (w > MAXW) ? 1 : 0; e.width = (w > MAXW) ? MAXW : w;
      end
      m_drop = m_new && (q.size() == DEPTH) && !m_pop;
      if (m_pop) void'(q.pop_front());
      if (m_new && !m_drop) q.push_back(e);
      if (m_drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_coarse = (m_coarse + 1) % (1 << CW);
    end
  end

  task automatic cyc();
    @(posedge clk300); #1;
  endtask

  task automatic goto_c(input int c);
    int n = 0;
    str = 1'b0;
    while (m_coarse != c && n < 5000) begin cyc(); n++; end
    if (m_coarse != c) begin
      checks++; errors++;
      $display("FAIL goto: coarse %0d expected %0d", m_coarse, c);
    end
  endtask

  task automatic drive_edge(input bit pin, input int pt);
    str = 1'b1; pin_out = pin; ptime = pt[2:0];
    cyc();
    str = 1'b0;
  endtask

  // Literal expectation for the current cycle, then move to the next cycle.
  task automatic expect_ev(input string tag, input int v, input int lead, input int width, input int sat);
    @(negedge clk300); #1;
    chk({tag, "_valid"}, bus.out_valid, v);
    if (v != 0) begin
      chk({tag, "_lead"},  bus.out_lead,  lead);
      chk({tag, "_width"}, bus.out_width, width);
      chk({tag, "_sat"},   bus.out_sat,   sat);
    end
    @(posedge clk300); #1;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk300);
    #1 rst = 1'b0;

    // basic pulse
    goto_c(5);  drive_edge(1, 2);
    goto_c(7);  drive_edge(0, 6);
    expect_ev("basic", 1, 42, 20, 0);

    // coarse wrap between rise and fall
    goto_c(4095); drive_edge(1, 7);
    drive_edge(0, 3);
    expect_ev("wrap", 1, 32767, 4, 0);

    // no fall: timeout exactly at coarse 512
    goto_c(0);  drive_edge(1, 0);
    goto_c(511);
    expect_ev("tmo_511", 0, 0, 0, 0);
    cyc();
    expect_ev("tmo", 1, 0, 4095, 1);
    drive_edge(0, 5);
    expect_ev("late_fall", 0, 0, 0, 0);
    expect_ev("late_fall2", 0, 0, 0, 0);

    // orphan fall, then rise/rise/fall
    goto_c(600); drive_edge(0, 1);
    expect_ev("orphan", 0, 0, 0, 0);
    goto_c(610); drive_edge(1, 1);
    goto_c(612); drive_edge(1, 3);
    goto_c(615); drive_edge(0, 0);
    expect_ev("rerise", 1, 4899, 21, 0);

    // overflow: five pulses into a stalled FIFO
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      goto_c(700 + 10 * i); drive_edge(1, i);
      goto_c(702 + 10 * i); drive_edge(0, i);
    end
    @(negedge clk300); #1;
    chk("ovf_set", ovf, 1);
    @(posedge clk300); #1;
    expect_ev("hold", 1, 5600, 16, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_ev("drain", 1, 5600 + 81 * i, 16, 0);
    expect_ev("drained", 0, 0, 0, 0);
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    @(negedge clk300); #1;
    chk("ovf_clr", ovf, 0);
    @(posedge clk300); #1;

    // write into full FIFO with simultaneous pop is accepted
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      goto_c(800 + 10 * i); drive_edge(1, 0);
      goto_c(802 + 10 * i); drive_edge(0, 0);
    end
    goto_c(840); drive_edge(1, 0);
    goto_c(842);
    bus.out_ready = 1'b1;
    drive_edge(0, 0);
    @(negedge clk300); #1;
    chk("fullpop_ovf", ovf, 0);
    @(posedge clk300); #1;
    goto_c(860);
    expect_ev("fullpop_empty", 0, 0, 0, 0);

    // reset while a lead is pending and an event is queued
    bus.out_ready = 1'b0;
    goto_c(900); drive_edge(1, 0);
    goto_c(902); drive_edge(0, 0);
    goto_c(905); drive_edge(1, 2);
    goto_c(908);
    #1 rst = 1'b1;
    @(negedge clk300); #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_lead",  bus.out_lead,  0);
    chk("arst_width", bus.out_width, 0);
    @(posedge clk300); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive_edge(0, 4);
    expect_ev("post_rst", 0, 0, 0, 0);
    expect_ev("post_rst2", 0, 0, 0, 0);
    goto_c(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
